// File: rtl/mm_counter_game.sv
// Multi-mode game counter with win/loss tallies and an IDLE/PLAY/OVER game FSM.
// Define MMC_SATURATE_EN to clamp steps at 0/max instead of wrapping modulo 2**WIDTH.
module mm_counter_game #(
    parameter int WIDTH      = 4,
    parameter int TALLY_W    = 4,
    parameter int RST_VAL    = 7,
    parameter int STEP_SMALL = 1,
    parameter int STEP_BIG   = 2,
    parameter int WIN_GOAL   = 15,
    parameter int LOSE_GOAL  = 15
) (
    input  logic               dclk,
    input  logic               rst,
    input  logic               start,
    input  logic               en,
    input  logic               INIT,
    input  logic [WIDTH-1:0]   inval,
    input  logic [1:0]         ctrl,
    output logic [WIDTH-1:0]   count,
    output logic [TALLY_W-1:0] W_count,
    output logic [TALLY_W-1:0] L_count,
    output logic               winner,
    output logic               loser,
    output logic               gameover
);

    localparam logic [WIDTH-1:0]   MAX_VAL   = '1;
    localparam logic [WIDTH-1:0]   RST_T     = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0]   SMALL_N   = WIDTH'(STEP_SMALL);
    localparam logic [WIDTH-1:0]   BIG_N     = WIDTH'(STEP_BIG);
    localparam logic [TALLY_W-1:0] WIN_T     = TALLY_W'(WIN_GOAL);
    localparam logic [TALLY_W-1:0] LOSE_T    = TALLY_W'(LOSE_GOAL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t state, nextState;

    logic [WIDTH-1:0]   stepN;
    logic [WIDTH-1:0]   stepped;
    logic [WIDTH-1:0]   countNext;
    logic [TALLY_W-1:0] wInc, lInc;
    logic [TALLY_W-1:0] wNext, lNext;
    logic               winnerNext, loserNext;

    assign stepN = ctrl[0] ? BIG_N : SMALL_N;
    assign wInc  = W_count + 1'b1;
    assign lInc  = L_count + 1'b1;

`ifdef MMC_SATURATE_EN
    logic [WIDTH:0] upSum, downDiff;

    // The extra top bit is the carry (up) or borrow (down) that triggers the clamp.
    always_comb begin
        upSum    = {1'b0, count} + {1'b0, stepN};
        downDiff = {1'b0, count} - {1'b0, stepN};
        if (ctrl[1])
            stepped = downDiff[WIDTH] ? '0 : downDiff[WIDTH-1:0];
        else
            stepped = upSum[WIDTH] ? MAX_VAL : upSum[WIDTH-1:0];
    end
`else
    assign stepped = ctrl[1] ? (count - stepN) : (count + stepN);
`endif

    // Tallies look at the pre-edge count, so INIT never suppresses a win/loss this cycle.
    always_comb begin
        nextState  = state;
        countNext  = count;
        wNext      = W_count;
        lNext      = L_count;
        winnerNext = winner;
        loserNext  = loser;
        case (state)
            IDLE: begin
                if (INIT) begin
                    countNext = inval;
                    nextState = PLAY;
                end else if (start) begin
                    nextState = PLAY;
                end
            end
            PLAY: begin
                if (en) begin
                    countNext = INIT ? inval : stepped;
                    if (count == MAX_VAL) begin
                        wNext = wInc;
                        if (wInc == WIN_T) begin
                            winnerNext = 1'b1;
                            nextState  = OVER;
                        end
                    end
                    if (count == '0) begin
                        lNext = lInc;
                        if (lInc == LOSE_T) begin
                            loserNext = 1'b1;
                            nextState = OVER;
                        end
                    end
                end
            end
            OVER: begin
                if (INIT) begin
                    countNext  = inval;
                    wNext      = '0;
                    lNext      = '0;
                    winnerNext = 1'b0;
                    loserNext  = 1'b0;
                    nextState  = PLAY;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= RST_T;
            W_count <= '0;
            L_count <= '0;
            winner  <= 1'b0;
            loser   <= 1'b0;
        end else begin
            state   <= nextState;
            count   <= countNext;
            W_count <= wNext;
            L_count <= lNext;
            winner  <= winnerNext;
            loser   <= loserNext;
        end
    end

    assign gameover = (state == OVER);

endmodule
